tag_lookup_ctrl: RTL and testbench
==================================

Name: tag_lookup_ctrl

Overview:
- Client-side controller for the synchronous-read tag RAM in the write-hit-check cache path.
- Accepts lookup requests over a valid/ready handshake and drives the RAM's addr/din/we port.
- Compares the RAM output one clock after the address is latched and returns hit/miss plus victim information.
- On write requests it allocates or marks the line dirty. After reset it optionally clears the whole tag RAM.

Parameters:
- AWIDTH, 3, index width; DEPTH = 1<<AWIDTH entries.
- DWIDTH, 14, tag RAM word width. Word format: bit[DWIDTH-1]=valid, bit[DWIDTH-2]=dirty, bits[DWIDTH-3:0]=tag. TWIDTH = DWIDTH-2.
- INIT_CLEAR, 1, 1 = write zero to every entry after reset before accepting requests.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high.
- req_valid, input, 1, request present.
- req_ready, output, 1, high only in IDLE.
- req_addr, input, TWIDTH+AWIDTH, {tag, index}; index = low AWIDTH bits.
- req_write, input, 1, 1 = write lookup, 0 = read lookup.
- resp_valid, output, 1, response present; held until accepted.
- resp_ready, input, 1, consumer accepts the response.
- resp_hit, output, 1, stored entry valid and tag matches.
- resp_victim_valid, output, 1, valid bit of the entry read.
- resp_victim_dirty, output, 1, dirty bit of the entry read.
- resp_victim_tag, output, TWIDTH, tag field of the entry read.
- ram_addr, output, AWIDTH, to tag RAM addr (registered).
- ram_din, output, DWIDTH, to tag RAM din (registered).
- ram_we, output, 1, to tag RAM we (registered).
- ram_dout, input, DWIDTH, from tag RAM dout; valid the cycle after ram_addr is latched by the RAM.
- init_busy, output, 1, high during the INIT sweep.

Behaviour:
- States: INIT, IDLE, ISSUE, COMPARE, UPDATE, RESP.
- Reset state: INIT if INIT_CLEAR=1, else IDLE.
- Reset values: ram_we=0, ram_addr=0, ram_din=0, resp_valid=0, all resp_* fields=0, init counter=0.
- INIT:
  - ram_we=1, ram_din=0, ram_addr=counter; counter increments each cycle.
  - After the write at index DEPTH-1 completes: go to IDLE with ram_we=0.
  - Duration is exactly DEPTH cycles. init_busy=1 and req_ready=0 throughout.
- IDLE:
  - req_ready=1. On req_valid&req_ready at edge k: capture tag and req_write; ram_addr<=index; go to ISSUE.
- ISSUE:
  - One cycle; the RAM latches ram_addr at edge k+1; go to COMPARE.
- COMPARE:
  - ram_dout is valid. Capture victim fields from ram_dout. hit = valid & (stored tag == captured tag).
  - Read request: go to RESP; no RAM change on hit or miss.
  - Write hit with dirty=1: go to RESP; no RAM write.
  - Write hit with dirty=0, or any write miss: ram_din<={1,1,tag}, ram_we<=1; go to UPDATE.
- UPDATE:
  - The RAM writes at the edge leaving UPDATE. ram_we<=0; go to RESP.
  - ram_addr holds the index from IDLE through UPDATE.
- RESP:
  - resp_valid=1; fields stable until the resp_valid&resp_ready edge, then go to IDLE with resp_valid=0.
  - Back-to-back requests: req_ready is next high the cycle after acceptance. No request overlap; one outstanding at most.
- Latency from acceptance edge k: read or dirty write hit gives resp_valid after edge k+2; write needing update gives resp_valid after edge k+3.
- Victim fields always report the pre-update contents.
- Reset asserted in any state: immediately ram_we=0 and resp_valid=0; the FSM returns to INIT/IDLE. An interrupted UPDATE write is not guaranteed. With INIT_CLEAR=1 the sweep re-runs in full.
- req_valid while not IDLE is ignored; it is not captured.
- resp_ready without resp_valid has no effect.

Test Plan:
- INIT sweep: release reset, AWIDTH=3 -> init_busy and ram_we high exactly 8 cycles, ram_addr 0..7, ram_din=0; then req_ready=1.
- Read miss: read 0x1235 after init -> resp_valid after edge k+2; hit=0, victim_valid=0; no ram_we pulse.
- Write allocate then read: write 0x1235 -> hit=0; RAM[5]=0x3246 and resp_valid after edge k+3. Then read 0x1235 -> hit=1, victim_dirty=1, victim_tag=0x246.
- Write hit on dirty line: second write to 0x1235 -> hit=1, no ram_we pulse, 2-edge latency.
- Conflict: write 0x2AB5 (index 5, tag 0x556) -> hit=0, victim_valid=1, victim_dirty=1, victim_tag=0x246; RAM[5]=0x3556.
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> fields stable and req_ready=0. Then assert reset during UPDATE -> ram_we drops at once, init_busy reasserts, and the 8-cycle sweep repeats.

Source files
------------

// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: client controller for a synchronous-read tag RAM.
// Looks up {tag,index}, reports hit/victim, allocates or dirties on writes.
//
// Ports:
//   clock, reset            clock, async active-high reset
//   req_valid/req_ready     request handshake; req_addr={tag,index}
//   req_write               1 = write lookup (allocate / mark dirty)
//   resp_valid/resp_ready   response handshake; resp_* held until accepted
//   resp_hit, resp_victim_* hit flag and pre-update entry contents
//   ram_addr/ram_din/ram_we registered tag RAM port; ram_dout RAM read data
//   init_busy               high while the post-reset clear sweep writes
module tag_lookup_ctrl #(
  parameter int AWIDTH     = 3,
  parameter int DWIDTH     = 14,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DWIDTH-3+AWIDTH:0] req_addr,
  input  logic                     req_write,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic                     resp_victim_valid,
  output logic                     resp_victim_dirty,
  output logic [DWIDTH-3:0]        resp_victim_tag,
  output logic [AWIDTH-1:0]        ram_addr,
  output logic [DWIDTH-1:0]        ram_din,
  output logic                     ram_we,
  input  logic [DWIDTH-1:0]        ram_dout,
  output logic                     init_busy
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    COMPARE,
    UPDATE,
    RESP
  } state_t;

  state_t              state_q;
  logic [AWIDTH-1:0]   cnt_q;
  logic [DWIDTH-3:0]   tag_q;
  logic                wr_q;
  logic                busy_q;
  logic [AWIDTH-1:0]   ram_addr_q;
  logic [DWIDTH-1:0]   ram_din_q;
  logic                ram_we_q;
  logic                resp_valid_q;
  logic                hit_q;
  logic                vv_q;
  logic                vd_q;
  logic [DWIDTH-3:0]   vt_q;

  logic                st_valid;
  logic                st_dirty;
  logic [DWIDTH-3:0]   st_tag;
  logic                st_hit;

  assign st_valid = ram_dout[DWIDTH-1];
  assign st_dirty = ram_dout[DWIDTH-2];
  assign st_tag   = ram_dout[DWIDTH-3:0];
  assign st_hit   = st_valid && (st_tag == tag_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= (INIT_CLEAR != 0) ? INIT : IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      vv_q         <= 1'b0;
      vd_q         <= 1'b0;
      vt_q         <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          // Leave once the last index's write has been presented for a cycle.
          if (ram_we_q && (ram_addr_q == '1)) begin
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            ram_we_q   <= 1'b1;
            ram_din_q  <= '0;
            ram_addr_q <= cnt_q;
            cnt_q      <= cnt_q + 1'b1;
            busy_q     <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            tag_q      <= req_addr[DWIDTH-3+AWIDTH:AWIDTH];
            wr_q       <= req_write;
            ram_addr_q <= req_addr[AWIDTH-1:0];
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= COMPARE;
        end
        COMPARE: begin
          hit_q <= st_hit;
          vv_q  <= st_valid;
          vd_q  <= st_dirty;
          vt_q  <= st_tag;
          // Only a write that already finds a dirty hit skips the RAM write.
          if (wr_q && !(st_hit && st_dirty)) begin
            ram_din_q <= {2'b11, tag_q};
            ram_we_q  <= 1'b1;
            state_q   <= UPDATE;
          end else begin
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        UPDATE: begin
          ram_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign init_busy         = busy_q;
  assign ram_addr          = ram_addr_q;
  assign ram_din           = ram_din_q;
  assign ram_we            = ram_we_q;
  assign resp_valid        = resp_valid_q;
  assign resp_hit          = hit_q;
  assign resp_victim_valid = vv_q;
  assign resp_victim_dirty = vd_q;
  assign resp_victim_tag   = vt_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb_tag_lookup_ctrl: directed bench for tag_lookup_ctrl.
// Drives on negedge, samples on negedge; includes a sync-read RAM model.
module tb_tag_lookup_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic        resp_victim_valid;
  logic        resp_victim_dirty;
  logic [11:0] resp_victim_tag;
  logic [2:0]  ram_addr;
  logic [13:0] ram_din;
  logic        ram_we;
  logic [13:0] ram_dout;
  logic        init_busy;

  logic [13:0] mem [8];

  int total  = 0;
  int passed = 0;

  tag_lookup_ctrl #(
    .AWIDTH(3),
    .DWIDTH(14),
    .INIT_CLEAR(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_hit(resp_hit),
    .resp_victim_valid(resp_victim_valid),
    .resp_victim_dirty(resp_victim_dirty),
    .resp_victim_tag(resp_victim_tag),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_we(ram_we),
    .ram_dout(ram_dout),
    .init_busy(init_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("init_we", 32'(ram_we), 32'd1);
      chk("init_addr", 32'(ram_addr), 32'(i));
      chk("init_din", 32'(ram_din), 32'd0);
      chk("init_busy", 32'(init_busy), 32'd1);
      chk("init_rdy", 32'(req_ready), 32'd0);
    end
    @(negedge clock);
    chk("init_end_we", 32'(ram_we), 32'd0);
    chk("init_end_busy", 32'(init_busy), 32'd0);
    chk("init_end_rdy", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input string nm,
                     input logic [14:0] a,
                     input logic w,
                     input int lat,
                     input logic hit,
                     input logic vv,
                     input logic vd,
                     input logic [11:0] vt,
                     input int we_exp,
                     input logic [13:0] din_exp);
    int n;
    int wen;
    logic [13:0] din_seen;
    req_addr  = a;
    req_write = w;
    req_valid = 1'b1;
    @(negedge clock);
    // Keep a stray request on the bus; it must be ignored while busy.
    req_addr  = 15'h7FFA;
    req_write = 1'b1;
    n = 0;
    wen = 0;
    din_seen = '0;
    while (!resp_valid && n < 10) begin
      chk({nm, "_addr_held"}, 32'(ram_addr), 32'(a[2:0]));
      if (ram_we) begin
        wen++;
        din_seen = ram_din;
      end
      @(negedge clock);
      n++;
    end
    req_valid = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_we_pulses"}, 32'(wen), 32'(we_exp));
    chk({nm, "_din"}, 32'(din_seen), 32'(din_exp));
    chk({nm, "_hit"}, 32'(resp_hit), 32'(hit));
    chk({nm, "_vvalid"}, 32'(resp_victim_valid), 32'(vv));
    chk({nm, "_vdirty"}, 32'(resp_victim_dirty), 32'(vd));
    chk({nm, "_vtag"}, 32'(resp_victim_tag), 32'(vt));
  endtask

  task automatic accept(input string nm);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk({nm, "_rv_drop"}, 32'(resp_valid), 32'd0);
    chk({nm, "_rdy_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_hit", 32'(resp_hit), 32'd0);
    chk("rst_vtag", 32'(resp_victim_tag), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    reset = 1'b0;
    sweep();

    txn("rd_miss", 15'h1235, 1'b0, 2, 1'b0, 1'b0, 1'b0,
        12'h000, 0, 14'h0000);
    accept("rd_miss");

    txn("wr_alloc", 15'h1235, 1'b1, 3, 1'b0, 1'b0, 1'b0,
        12'h000, 1, 14'h3246);
    accept("wr_alloc");
    chk("mem5_alloc", 32'(mem[5]), 32'h3246);

    txn("rd_hit", 15'h1235, 1'b0, 2, 1'b1, 1'b1, 1'b1,
        12'h246, 0, 14'h0000);
    accept("rd_hit");

    txn("wr_dirty", 15'h1235, 1'b1, 2, 1'b1, 1'b1, 1'b1,
        12'h246, 0, 14'h0000);
    accept("wr_dirty");

    txn("conflict", 15'h2AB5, 1'b1, 3, 1'b0, 1'b1, 1'b1,
        12'h246, 1, 14'h3556);
    accept("conflict");
    chk("mem5_conf", 32'(mem[5]), 32'h3556);

    txn("bp_rd", 15'h2AB5, 1'b0, 2, 1'b1, 1'b1, 1'b1,
        12'h556, 0, 14'h0000);
    req_valid = 1'b1;
    req_addr  = 15'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_rv", 32'(resp_valid), 32'd1);
      chk("bp_hit", 32'(resp_hit), 32'd1);
      chk("bp_vtag", 32'(resp_victim_tag), 32'h556);
      chk("bp_rdy", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    accept("bp");

    req_addr  = 15'h0003;
    req_write = 1'b1;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!ram_we && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("upd_reached", 32'(n), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_upd_we", 32'(ram_we), 32'd0);
    chk("rst_upd_rv", 32'(resp_valid), 32'd0);
    chk("rst_upd_rdy", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sweep();

    txn("post_clr", 15'h2AB5, 1'b0, 2, 1'b0, 1'b0, 1'b0,
        12'h000, 0, 14'h0000);
    accept("post_clr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
